// File: rtl/lc_mode_sched.sv
// lc_mode_sched: link-controller mode scheduler. Latches the one-shot
// Page/Inquiry/PageScan/InquiryScan requests and grants one mode at a
// time on slot boundaries, with a per-mode slot timeout and a one-slot
// guard gap between successive grants.
// Optional macro LC_SCHED_RR_EN: round-robin arbitration instead of the
// fixed priority 2 > 3 > 0 > 1.
// Ports:
//   clk_6M, rst          clock, synchronous active-high reset
//   tslot_p              slot boundary pulse
//   req_oneshot          request pulses (0 PS, 1 IS, 2 Page, 3 Inq)
//   cancel_oneshot       cancel pending request / abort active mode
//   done_p               active procedure finished
//   conn_busy            blocks new grants
//   regi_*               per-mode slot limits (0 = no timeout)
//   mode_en              one-hot active mode
//   mode_start_p         grant pulse
//   timeout_p            expiry pulse
//   pending              latched, not-yet-granted requests
//   busy                 scheduler not idle
module lc_mode_sched #(
   parameter int NMODE = 4,
   parameter int TW    = 16
) (
   input  logic             clk_6M,
   input  logic             rst,
   input  logic             tslot_p,
   input  logic [NMODE-1:0] req_oneshot,
   input  logic [NMODE-1:0] cancel_oneshot,
   input  logic             done_p,
   input  logic             conn_busy,
   input  logic [TW-1:0]    regi_Tpswindow,
   input  logic [TW-1:0]    regi_Tiswindow,
   input  logic [TW-1:0]    regi_Page_Timeout,
   input  logic [TW-1:0]    regi_Inquiry_Timeout,
   output logic [NMODE-1:0] mode_en,
   output logic             mode_start_p,
   output logic             timeout_p,
   output logic [NMODE-1:0] pending,
   output logic             busy
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACTIVE = 2'd1,
      S_GUARD  = 2'd2
   } state_e;

   state_e           state_q;
   logic [NMODE-1:0] mode_en_q;
   logic [NMODE-1:0] pending_q;
   logic [NMODE-1:0] pending_d;
   logic [NMODE-1:0] grant_oh;
   logic             start_q;
   logic             tout_q;
   logic [TW-1:0]    cnt_q;
   logic [TW-1:0]    lim_sel;
   logic [1:0]       gsel;
   logic             grant;
   logic             act_cancel;

`ifdef LC_SCHED_RR_EN
   logic [1:0] ptr_q;
   logic [1:0] cand;
   logic       found;

   // Search starts one past the last granted index.
   always_comb begin
      gsel  = ptr_q;
      cand  = ptr_q;
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         cand = ptr_q + 2'(k);
         if (!found && pending_q[cand]) begin
            gsel  = cand;
            found = 1'b1;
         end
      end
   end
`else
   always_comb begin
      if (pending_q[2])      gsel = 2'd2;
      else if (pending_q[3]) gsel = 2'd3;
      else if (pending_q[0]) gsel = 2'd0;
      else                   gsel = 2'd1;
   end
`endif

   always_comb begin
      unique case (gsel)
         2'd0:    lim_sel = regi_Tpswindow;
         2'd1:    lim_sel = regi_Tiswindow;
         2'd2:    lim_sel = regi_Page_Timeout;
         default: lim_sel = regi_Inquiry_Timeout;
      endcase
   end

   assign grant = (state_q == S_IDLE) && tslot_p
                  && (|pending_q) && !conn_busy;
   assign grant_oh = grant ? (NMODE'(1) << gsel) : '0;

   // Granted bit is consumed first so a same-cycle request re-arms it;
   // cancel overrides any request on the same bit.
   assign pending_d = ((pending_q & ~grant_oh) | req_oneshot)
                      & ~cancel_oneshot;

   assign act_cancel = |(cancel_oneshot & mode_en_q);

   always_ff @(posedge clk_6M) begin
      if (rst) begin
         state_q   <= S_IDLE;
         mode_en_q <= '0;
         pending_q <= '0;
         start_q   <= 1'b0;
         tout_q    <= 1'b0;
         cnt_q     <= '0;
`ifdef LC_SCHED_RR_EN
         ptr_q     <= 2'd0;
`endif
      end else begin
         pending_q <= pending_d;
         start_q   <= 1'b0;
         tout_q    <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (grant) begin
                  state_q   <= S_ACTIVE;
                  mode_en_q <= grant_oh;
                  cnt_q     <= lim_sel;
                  start_q   <= 1'b1;
`ifdef LC_SCHED_RR_EN
                  ptr_q     <= gsel;
`endif
               end
            end
            S_ACTIVE: begin
               if (done_p || act_cancel) begin
                  state_q   <= S_GUARD;
                  mode_en_q <= '0;
               end else if (tslot_p) begin
                  if (cnt_q == TW'(1)) begin
                     state_q   <= S_GUARD;
                     mode_en_q <= '0;
                     tout_q    <= 1'b1;
                  end else if (cnt_q != '0) begin
                     // Zero limit holds: no timeout.
                     cnt_q <= cnt_q - TW'(1);
                  end
               end
            end
            S_GUARD: begin
               if (tslot_p) state_q <= S_IDLE;
            end
            default: begin
               state_q   <= S_IDLE;
               mode_en_q <= '0;
            end
         endcase
      end
   end

   assign mode_en      = mode_en_q;
   assign mode_start_p = start_q;
   assign timeout_p    = tout_q;
   assign pending      = pending_q;
   assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_lc_mode_sched.sv
// tb_lc_mode_sched: directed scenarios plus random stimulus against a
// slot-level behavioural model of the mode scheduler.
module tb_lc_mode_sched;

   logic        clk_6M = 1'b0;
   logic        rst = 1'b1;
   logic        tslot_p = 1'b0;
   logic [3:0]  req_oneshot = '0;
   logic [3:0]  cancel_oneshot = '0;
   logic        done_p = 1'b0;
   logic        conn_busy = 1'b0;
   logic [15:0] regi_Tpswindow = 16'd2;
   logic [15:0] regi_Tiswindow = 16'd2;
   logic [15:0] regi_Page_Timeout = 16'd3;
   logic [15:0] regi_Inquiry_Timeout = 16'd2;
   logic [3:0]  mode_en;
   logic        mode_start_p;
   logic        timeout_p;
   logic [3:0]  pending;
   logic        busy;

   lc_mode_sched dut (
      .clk_6M               (clk_6M),
      .rst                  (rst),
      .tslot_p              (tslot_p),
      .req_oneshot          (req_oneshot),
      .cancel_oneshot       (cancel_oneshot),
      .done_p               (done_p),
      .conn_busy            (conn_busy),
      .regi_Tpswindow       (regi_Tpswindow),
      .regi_Tiswindow       (regi_Tiswindow),
      .regi_Page_Timeout    (regi_Page_Timeout),
      .regi_Inquiry_Timeout (regi_Inquiry_Timeout),
      .mode_en              (mode_en),
      .mode_start_p         (mode_start_p),
      .timeout_p            (timeout_p),
      .pending              (pending),
      .busy                 (busy)
   );

   always #5 clk_6M = ~clk_6M;

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Behavioural model: which mode runs and how many slots it has left.
   bit         m_active;
   bit         m_guard;
   int         m_idx;
   int         m_left;
   logic [3:0] m_pend;
   int         m_last;
   bit         m_start;
   bit         m_tout;
   bit         cb_v;
   int         grants[$];

   function automatic int lim_of(input int i);
      case (i)
         0:       return int'(regi_Tpswindow);
         1:       return int'(regi_Tiswindow);
         2:       return int'(regi_Page_Timeout);
         default: return int'(regi_Inquiry_Timeout);
      endcase
   endfunction

   function automatic int pick(input logic [3:0] p);
`ifdef LC_SCHED_RR_EN
      for (int k = 1; k <= 4; k++)
         if (p[(m_last + k) % 4]) return (m_last + k) % 4;
`else
      int ord[4] = '{2, 3, 0, 1};
      for (int k = 0; k < 4; k++)
         if (p[ord[k]]) return ord[k];
`endif
      return -1;
   endfunction

   task automatic model_step(input logic r, input logic ts,
                             input logic [3:0] rq, input logic [3:0] cn,
                             input logic dn, input logic cb);
      bit was_act, was_grd;
      int g;
      logic [3:0] np;
      if (r) begin
         m_active = 0; m_guard = 0; m_idx = 0; m_left = 0;
         m_pend = '0; m_last = 0; m_start = 0; m_tout = 0;
         return;
      end
      was_act = m_active;
      was_grd = m_guard;
      m_start = 0;
      m_tout = 0;
      g = -1;
      if (!was_act && !was_grd && ts && m_pend != 0 && !cb)
         g = pick(m_pend);
      np = m_pend;
      if (g >= 0) np[g] = 1'b0;
      np = (np | rq) & ~cn;
      if (g >= 0) begin
         m_active = 1;
         m_idx = g;
         m_left = lim_of(g);
         m_start = 1;
         m_last = g;
      end else if (was_act) begin
         if (dn || cn[m_idx]) begin
            m_active = 0; m_guard = 1;
         end else if (ts && m_left == 1) begin
            m_active = 0; m_guard = 1; m_tout = 1;
         end else if (ts && m_left > 1) begin
            m_left--;
         end
      end else if (was_grd && ts) begin
         m_guard = 0;
      end
      m_pend = np;
   endtask

   function automatic int idx_of(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic step(input logic r, input logic ts,
                       input logic [3:0] rq, input logic [3:0] cn,
                       input logic dn);
      logic [3:0] e_en;
      rst = r;
      tslot_p = ts;
      req_oneshot = rq;
      cancel_oneshot = cn;
      done_p = dn;
      conn_busy = cb_v;
      model_step(r, ts, rq, cn, dn, cb_v);
      @(negedge clk_6M);
      e_en = m_active ? (4'b0001 << m_idx) : 4'b0000;
      check("mode_en", 32'(mode_en), 32'(e_en));
      check("pending", 32'(pending), 32'(m_pend));
      check("start", 32'(mode_start_p), 32'(m_start));
      check("timeout", 32'(timeout_p), 32'(m_tout));
      check("busy", 32'(busy), 32'(m_active | m_guard));
      if (mode_start_p) grants.push_back(idx_of(mode_en));
   endtask

   task automatic slots(input int n);
      for (int i = 0; i < n; i++) begin
         repeat (3) step(0, 0, 4'b0000, 4'b0000, 0);
         step(0, 1, 4'b0000, 4'b0000, 0);
      end
   endtask

   int exp_ord[4];

   initial begin
      cb_v = 0;
      step(1, 0, 4'b0000, 4'b0000, 0);
      step(1, 0, 4'b0000, 4'b0000, 0);

      // Page with limit 3
      regi_Page_Timeout = 16'd3;
      step(0, 0, 4'b0100, 4'b0000, 0);
      slots(6);
      check("page_grants", 32'(grants.size()), 32'd1);
      if (grants.size() > 0) check("page_idx", 32'(grants[0]), 32'd2);

      // All four requests, limits 2
      grants.delete();
      regi_Tpswindow = 16'd2;
      regi_Tiswindow = 16'd2;
      regi_Page_Timeout = 16'd2;
      regi_Inquiry_Timeout = 16'd2;
      step(0, 0, 4'b1111, 4'b0000, 0);
      slots(20);
`ifdef LC_SCHED_RR_EN
      exp_ord = '{3, 0, 1, 2};
`else
      exp_ord = '{2, 3, 0, 1};
`endif
      check("order_cnt", 32'(grants.size()), 32'd4);
      for (int i = 0; i < 4; i++)
         if (i < grants.size())
            check($sformatf("order%0d", i), 32'(grants[i]),
                  32'(exp_ord[i]));

      // PageScan limit 5, done+cancel on expiry slot
      regi_Tpswindow = 16'd5;
      step(0, 0, 4'b0001, 4'b0000, 0);
      slots(1);
      check("ps_en", 32'(mode_en), 32'h1);
      slots(4);
      repeat (3) step(0, 0, 4'b0000, 4'b0000, 0);
      step(0, 1, 4'b0000, 4'b0001, 1);
      check("dc_to", 32'(timeout_p), 32'd0);
      check("dc_pend", 32'(pending), 32'd0);
      slots(2);

      // conn_busy blocks grants
      cb_v = 1;
      step(0, 0, 4'b0010, 4'b0000, 0);
      slots(10);
      check("cb_idle", 32'(busy), 32'd0);
      cb_v = 0;
      slots(1);
      check("cb_grant", 32'(mode_en), 32'h2);
      slots(4);

      // Reset while active with Inquiry pending
      regi_Page_Timeout = 16'd0;
      step(0, 0, 4'b0100, 4'b0000, 0);
      slots(1);
      step(0, 0, 4'b1000, 4'b0000, 0);
      slots(1);
      step(1, 0, 4'b0000, 4'b0000, 0);
      check("rst_en", 32'(mode_en), 32'd0);
      check("rst_pend", 32'(pending), 32'd0);
      slots(5);
      check("rst_nogrant", 32'(busy), 32'd0);

      // Random traffic
      for (int n = 0; n < 4000; n++) begin
         logic r, ts, dn;
         logic [3:0] rq, cn;
         if ($urandom_range(0, 49) == 0) cb_v = ~cb_v;
         if ($urandom_range(0, 29) == 0) begin
            case ($urandom_range(0, 3))
               0: regi_Tpswindow = 16'($urandom_range(0, 4));
               1: regi_Tiswindow = 16'($urandom_range(0, 4));
               2: regi_Page_Timeout = 16'($urandom_range(0, 4));
               default: regi_Inquiry_Timeout = 16'($urandom_range(0, 4));
            endcase
         end
         r  = ($urandom_range(0, 799) == 0);
         ts = ($urandom_range(0, 5) == 0);
         rq = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
         cn = ($urandom_range(0, 39) == 0) ? 4'($urandom) : 4'b0000;
         dn = ($urandom_range(0, 59) == 0);
         step(r, ts, rq, cn, dn);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
